// File: rtl/wb_port_arbiter_pkg.sv
// Shared writeback types and constants for the regfile write-port arbiter and
// the pipeline stage registers that feed it.
package wb_port_arbiter_pkg;

    localparam int WB_REG_AW = 5;
    localparam int WB_DATA_W = 32;

    typedef struct packed {
        logic [WB_REG_AW-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    localparam logic [WB_DATA_W-1:0] DATA_INVALID     = '0;
    localparam logic [WB_REG_AW-1:0] REG_ADDR_INVALID = '0;

endpackage

// File: rtl/wb_lu_fifo.sv
// Small synchronous FIFO holding long-latency writeback results. The pointers
// carry an extra wrap bit so that full and empty can be told apart.
module wb_lu_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count     = wr_ptr - rd_ptr;
    assign head_data = mem[rd_ptr[PTR_W-1:0]];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single regfile write port between the in-order pipeline writeback
// and buffered long-latency results, with starvation-bounded priority.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int LU_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              pipe_valid,
    output logic              pipe_ready,
    input  logic [ADDR_W-1:0] pipe_pc,
    input  logic [DATA_W-1:0] pipe_inst,
    input  logic              pipe_rw_en,
    input  logic [REG_AW-1:0] pipe_rw_addr,
    input  logic [DATA_W-1:0] pipe_rw_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [REG_AW-1:0] lu_rw_addr,
    input  logic [DATA_W-1:0] lu_rw_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              commit_valid,
    output logic [ADDR_W-1:0] commit_pc,
    output logic [DATA_W-1:0] commit_inst,
    output logic              lu_pending
);

    localparam int REQ_W = REG_AW + DATA_W;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    logic [REQ_W-1:0]           lu_head;
    logic                       lu_full;
    logic                       lu_empty;
    logic [$clog2(LU_DEPTH):0]  lu_count;
    logic                       lu_push;
    logic                       lu_grant;
    logic [SC_W-1:0]            starve_cnt;
    logic                       pipe_needs_port;
    logic                       force_lu;
    logic                       pipe_fire;
    logic                       pipe_wins;
    logic                       port_grant;
    logic [REG_AW-1:0]          win_addr;
    logic [DATA_W-1:0]          win_data;

    assign lu_ready   = !lu_full;
    assign lu_pending = (lu_count != '0);
    assign lu_push    = lu_valid && lu_ready;

    wb_lu_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (LU_DEPTH)
    ) u_lu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lu_push),
        .push_data ({lu_rw_addr, lu_rw_data}),
        .pop       (lu_grant),
        .head_data (lu_head),
        .full      (lu_full),
        .empty     (lu_empty),
        .count     (lu_count)
    );

    assign pipe_needs_port = pipe_valid && pipe_rw_en && !flush;
    assign force_lu        = lu_pending && (lu_full || starve_cnt == SC_W'(STARVE_MAX));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lu_grant   = 1'b0;
        pipe_ready = 1'b1;
        if (force_lu) begin
            lu_grant   = 1'b1;
            pipe_ready = !pipe_rw_en;
        end else if (!pipe_needs_port) begin
            lu_grant   = lu_pending;
        end
    end

    assign pipe_fire  = pipe_valid && pipe_ready && !flush;
    assign pipe_wins  = pipe_fire && pipe_rw_en;
    assign port_grant = lu_grant || pipe_wins;
    assign win_addr   = lu_grant ? lu_head[DATA_W +: REG_AW] : pipe_rw_addr;
    assign win_data   = lu_grant ? lu_head[DATA_W-1:0]      : pipe_rw_data;

    // Counts cycles the buffered head lost the port; the head popping resets it.
    always_ff @(posedge clk) begin
        if (rst || lu_empty || lu_grant)
            starve_cnt <= '0;
        else if (pipe_wins && starve_cnt != SC_W'(STARVE_MAX))
            starve_cnt <= starve_cnt + SC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we        <= 1'b0;
            rf_waddr     <= REG_AW'(REG_ADDR_INVALID);
            rf_wdata     <= DATA_W'(DATA_INVALID);
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_inst  <= '0;
        end else begin
            rf_we        <= port_grant && (win_addr != '0);
            commit_valid <= pipe_fire;
            if (port_grant) begin
                rf_waddr <= win_addr;
                rf_wdata <= win_data;
            end
            if (pipe_fire) begin
                commit_pc   <= pipe_pc;
                commit_inst <= pipe_inst;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter: basic writeback, buffered
// results, starvation forcing, full FIFO, flush, r0 suppression and reset.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              pipe_valid;
    logic              pipe_ready;
    logic [ADDR_W-1:0] pipe_pc;
    logic [DATA_W-1:0] pipe_inst;
    logic              pipe_rw_en;
    logic [REG_AW-1:0] pipe_rw_addr;
    logic [DATA_W-1:0] pipe_rw_data;
    logic              lu_valid;
    logic              lu_ready;
    logic [REG_AW-1:0] lu_rw_addr;
    logic [DATA_W-1:0] lu_rw_data;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              commit_valid;
    logic [ADDR_W-1:0] commit_pc;
    logic [DATA_W-1:0] commit_inst;
    logic              lu_pending;

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .REG_AW     (REG_AW),
        .LU_DEPTH   (2),
        .STARVE_MAX (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .pipe_valid   (pipe_valid),
        .pipe_ready   (pipe_ready),
        .pipe_pc      (pipe_pc),
        .pipe_inst    (pipe_inst),
        .pipe_rw_en   (pipe_rw_en),
        .pipe_rw_addr (pipe_rw_addr),
        .pipe_rw_data (pipe_rw_data),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_rw_addr   (lu_rw_addr),
        .lu_rw_data   (lu_rw_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .lu_pending   (lu_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush      = 1'b0;
        pipe_valid = 1'b0;
        pipe_rw_en = 1'b0;
        lu_valid   = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] inst_of(input logic [ADDR_W-1:0] pc);
        return pc ^ 32'h0000_0013;
    endfunction

    task automatic set_pipe(input logic rw_en, input logic [REG_AW-1:0] addr,
                            input logic [DATA_W-1:0] data, input logic [ADDR_W-1:0] pc);
        pipe_valid   = 1'b1;
        pipe_rw_en   = rw_en;
        pipe_rw_addr = addr;
        pipe_rw_data = data;
        pipe_pc      = pc;
        pipe_inst    = inst_of(pc);
    endtask

    task automatic set_lu(input wb_req_t r);
        lu_valid   = 1'b1;
        lu_rw_addr = r.addr;
        lu_rw_data = r.data;
    endtask

    task automatic expect_wr(input string tag, input logic we,
                             input logic [REG_AW-1:0] addr, input logic [DATA_W-1:0] data);
        check({tag, ".rf_we"},    64'(rf_we),    64'(we));
        check({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(addr));
        check({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(data));
    endtask

    initial begin
        rst          = 1'b1;
        pipe_pc      = '0;
        pipe_inst    = '0;
        pipe_rw_addr = '0;
        pipe_rw_data = '0;
        lu_rw_addr   = '0;
        lu_rw_data   = '0;
        idle_inputs();
        tick();
        tick();

        // Reset state
        expect_wr("rst", 1'b0, 5'd0, 32'h0);
        check("rst.commit_valid", 64'(commit_valid), 64'd0);
        check("rst.commit_pc",    64'(commit_pc),    64'd0);
        check("rst.lu_pending",   64'(lu_pending),   64'd0);
        check("rst.lu_ready",     64'(lu_ready),     64'd1);

        rst = 1'b0;
        tick();

        // Basic pipeline write
        set_pipe(1'b1, 5'd5, 32'h1234, 32'h100);
        #1 check("p1.pipe_ready", 64'(pipe_ready), 64'd1);
        tick();
        idle_inputs();
        expect_wr("p1", 1'b1, 5'd5, 32'h1234);
        check("p1.commit_valid", 64'(commit_valid), 64'd1);
        check("p1.commit_pc",    64'(commit_pc),    64'h100);
        check("p1.commit_inst",  64'(commit_inst),  64'(inst_of(32'h100)));
        tick();
        expect_wr("p1.hold", 1'b0, 5'd5, 32'h1234);
        check("p1.commit_clr", 64'(commit_valid), 64'd0);

        // Single buffered result with no pipeline traffic
        set_lu('{addr: 5'd7, data: 32'hAA});
        #1 check("lu1.lu_ready", 64'(lu_ready), 64'd1);
        tick();
        idle_inputs();
        check("lu1.pending", 64'(lu_pending), 64'd1);
        check("lu1.no_we",   64'(rf_we),      64'd0);
        tick();
        expect_wr("lu1", 1'b1, 5'd7, 32'hAA);
        check("lu1.drained", 64'(lu_pending), 64'd0);

        // Starvation: continuous pipeline writes with one entry pending
        set_pipe(1'b1, 5'd1, 32'h11, 32'h200);
        set_lu('{addr: 5'd9, data: 32'h99});
        tick();
        lu_valid = 1'b0;
        check("st.first_waddr", 64'(rf_waddr), 64'd1);
        for (int k = 0; k < 4; k++) begin
            set_pipe(1'b1, 5'(10 + k), 32'(32'h100 + k), 32'(32'h204 + 4 * k));
            #1 check($sformatf("st.ready%0d", k), 64'(pipe_ready), 64'd1);
            tick();
            check($sformatf("st.waddr%0d", k), 64'(rf_waddr), 64'(10 + k));
        end
        set_pipe(1'b1, 5'd20, 32'h2020, 32'h214);
        #1 check("st.forced_ready", 64'(pipe_ready), 64'd0);
        tick();
        expect_wr("st.lu", 1'b1, 5'd9, 32'h99);
        check("st.no_commit", 64'(commit_valid), 64'd0);
        check("st.drained",   64'(lu_pending),   64'd0);
        #1 check("st.resume_ready", 64'(pipe_ready), 64'd1);
        tick();
        idle_inputs();
        expect_wr("st.resume", 1'b1, 5'd20, 32'h2020);
        check("st.resume_commit", 64'(commit_valid), 64'd1);

        // Fill the FIFO under pipeline writes
        set_pipe(1'b1, 5'd2, 32'h22, 32'h300);
        set_lu('{addr: 5'd3, data: 32'h33});
        tick();
        check("fl.waddr2", 64'(rf_waddr), 64'd2);
        set_pipe(1'b1, 5'd6, 32'h66, 32'h304);
        set_lu('{addr: 5'd4, data: 32'h44});
        #1 check("fl.ready_b", 64'(pipe_ready), 64'd1);
        check("fl.lu_ready_b", 64'(lu_ready), 64'd1);
        tick();
        check("fl.waddr6", 64'(rf_waddr), 64'd6);
        lu_valid = 1'b0;
        set_pipe(1'b1, 5'd8, 32'h88, 32'h308);
        #1 check("fl.full_lu_ready", 64'(lu_ready), 64'd0);
        check("fl.full_pipe_ready", 64'(pipe_ready), 64'd0);
        tick();
        expect_wr("fl.pop3", 1'b1, 5'd3, 32'h33);
        check("fl.pop3_commit", 64'(commit_valid), 64'd0);
        set_lu('{addr: 5'd11, data: 32'hBB});
        #1 check("fl.refill_ready", 64'(pipe_ready), 64'd1);
        tick();
        lu_valid = 1'b0;
        expect_wr("fl.p8", 1'b1, 5'd8, 32'h88);
        check("fl.p8_commit_pc", 64'(commit_pc), 64'h308);
        set_pipe(1'b0, 5'd9, 32'h99, 32'h30C);
        #1 check("fl.nowrite_ready", 64'(pipe_ready), 64'd1);
        check("fl.nowrite_lu_ready", 64'(lu_ready), 64'd0);
        tick();
        idle_inputs();
        expect_wr("fl.pop4", 1'b1, 5'd4, 32'h44);
        check("fl.pop4_commit",    64'(commit_valid), 64'd1);
        check("fl.pop4_commit_pc", 64'(commit_pc),    64'h30C);
        tick();
        expect_wr("fl.pop11", 1'b1, 5'd11, 32'hBB);
        check("fl.drained", 64'(lu_pending), 64'd0);

        // Flush
        set_pipe(1'b1, 5'd13, 32'hDD, 32'h400);
        flush = 1'b1;
        tick();
        idle_inputs();
        check("fx.no_commit", 64'(commit_valid), 64'd0);
        check("fx.no_we",     64'(rf_we),        64'd0);
        set_lu('{addr: 5'd12, data: 32'hCC});
        tick();
        lu_valid = 1'b0;
        set_pipe(1'b1, 5'd13, 32'hDD, 32'h400);
        flush = 1'b1;
        tick();
        idle_inputs();
        check("fx.lu_no_commit", 64'(commit_valid), 64'd0);
        expect_wr("fx.lu", 1'b1, 5'd12, 32'hCC);
        check("fx.drained", 64'(lu_pending), 64'd0);

        // Write to r0 is committed but suppressed
        set_pipe(1'b1, 5'd0, 32'hFFFF, 32'h500);
        tick();
        idle_inputs();
        check("r0.commit", 64'(commit_valid), 64'd1);
        check("r0.no_we",  64'(rf_we),        64'd0);
        check("r0.pc",     64'(commit_pc),    64'h500);

        // Reset with two buffered entries
        set_pipe(1'b1, 5'd1, 32'h1, 32'h504);
        set_lu('{addr: 5'd14, data: 32'hE1});
        tick();
        set_pipe(1'b1, 5'd2, 32'h2, 32'h508);
        set_lu('{addr: 5'd15, data: 32'hE2});
        tick();
        idle_inputs();
        check("rr.full",    64'(lu_ready),   64'd0);
        check("rr.pending", 64'(lu_pending), 64'd1);
        rst = 1'b1;
        tick();
        expect_wr("rr", 1'b0, 5'd0, 32'h0);
        check("rr.commit_valid", 64'(commit_valid), 64'd0);
        check("rr.commit_pc",    64'(commit_pc),    64'd0);
        check("rr.commit_inst",  64'(commit_inst),  64'd0);
        check("rr.lu_pending",   64'(lu_pending),   64'd0);
        check("rr.lu_ready",     64'(lu_ready),     64'd1);
        rst = 1'b0;
        tick();
        tick();
        check("rr.no_ghost_we", 64'(rf_we),      64'd0);
        check("rr.still_empty", 64'(lu_pending), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single regfile write port between two sources:
  - the in-order pipeline writeback stream, fed from the MEM/WB stage register;
  - results from long-latency units (mul/div, CSR/uncached load return), which complete out of band.
- Holds long-latency results in a small FIFO and arbitrates each cycle.
- Backpressures the pipeline via pipe_ready when the long-latency side must win the port.
- Registers the winning write to the regfile and emits pipeline commit info for trace/difftest.

Parameters:
- ADDR_W, 32, PC width
- DATA_W, 32, register data / instruction width
- REG_AW, 5, register address width
- LU_DEPTH, 2, long-latency FIFO entries (power of two, >=2)
- STARVE_MAX, 4, consecutive lost-arbitration cycles before the long-latency side is forced to win

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard the current-cycle pipeline request
- pipe_valid  in  1  pipeline writeback request valid
- pipe_ready  out  1  pipeline request accepted this cycle
- pipe_pc  in  ADDR_W  PC of the pipeline instruction
- pipe_inst  in  DATA_W  instruction word
- pipe_rw_en  in  1  pipeline instruction writes the regfile
- pipe_rw_addr  in  REG_AW  destination register
- pipe_rw_data  in  DATA_W  write data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept a result (= !full)
- lu_rw_addr  in  REG_AW  destination register
- lu_rw_data  in  DATA_W  result data
- rf_we  out  1  regfile write enable
- rf_waddr  out  REG_AW  regfile write address
- rf_wdata  out  DATA_W  regfile write data
- commit_valid  out  1  pipeline instruction retired
- commit_pc  out  ADDR_W  retired PC
- commit_inst  out  DATA_W  retired instruction
- lu_pending  out  1  FIFO non-empty

Behaviour:
- Reset (rst=1, synchronous, active-high; clock clk): all outputs 0, FIFO empty, starvation counter 0. Reset mid-operation drops buffered results.
- Handshakes:
  - A pipeline transfer occurs on pipe_valid & pipe_ready & !flush.
  - A long-latency transfer occurs on lu_valid & lu_ready.
  - pipe_valid and lu_valid must be held with stable payload until accepted.
- FIFO: LU_DEPTH entries of {addr, data}, wrap-around pointers plus an extra wrap bit for full/empty.
  - Push and pop in the same cycle while full is legal: lu_ready stays 0 that cycle, so no push occurs; the pop frees a slot for the next cycle.
  - Push while empty with no pop: the entry becomes visible to arbitration in the next cycle; there is no same-cycle bypass.
- Arbitration (combinational, per cycle):
  - pipe_needs_port = pipe_valid & pipe_rw_en & !flush.
  - force_lu = lu_pending & (full | starve_cnt == STARVE_MAX).
  - If force_lu: the FIFO head wins and pipe_ready = !pipe_rw_en, so non-writing pipeline instructions still retire.
  - Else if pipe_needs_port: the pipeline wins, pipe_ready = 1, and the FIFO head waits.
  - Else: the FIFO head wins if present, and pipe_ready = 1.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, when lu_pending and the pipeline won the port.
  - Clears when the head is popped, or when the FIFO is empty.
- Output stage: registered, latency 1 cycle from grant.
  - rf_we = granted & addr != 0. Writes to r0 are consumed but suppressed.
  - rf_waddr and rf_wdata are held from the last grant when rf_we = 0.
  - commit_valid = registered pipeline transfer; commit_pc/commit_inst are the payload.
  - A flush in the same cycle suppresses commit and the write.
- Ordering:
  - Pipeline commits are strictly in order.
  - Long-latency results are in FIFO order.
  - WAW between the two sources is excluded by the issue scoreboard and is not checked here.

Decomposition:
- Shared package: wb_req_t struct {addr, data}, plus DATA_INVALID / REG_ADDR_INVALID constants already used by the stage registers.
- One sub-module: wb_lu_fifo (parameterised sync FIFO with full/empty/count).

Test Plan:
- Idle, then pipe_valid with rw_en=1, addr=5, data=0x1234 -> pipe_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, commit_valid=1.
- lu push addr=7, data=0xAA with no pipeline traffic -> lu_pending=1; wins one cycle later; rf_we=1 for addr 7 the cycle after that.
- Continuous pipeline writes with one lu entry pending -> lu wins on the cycle starve_cnt hits 4: pipe_ready=0 that cycle, rf_waddr = lu addr next cycle, counter cleared.
- Fill the FIFO (2 entries) under pipeline writes -> lu_ready=0, lu forced, pipe_ready=0; with pipe_rw_en=0, pipe_ready=1 and both the commit and the lu write occur next cycle.
- flush with pipe_valid=1, rw_en=1 -> no commit_valid, no rf_we; a pending lu entry is granted that same cycle.
- pipe write to r0, data=0xFFFF -> commit_valid=1, rf_we=0; rst asserted with 2 entries buffered -> next cycle lu_pending=0, lu_ready=1, all outputs 0.
